// File: rtl/regdi_lane_gen_if.sv
// Lane control and observation signals for one regdi_lane_gen instance.
// The master drives the level, load, direction and pause controls; the slave returns the lane state.
interface regdi_lane_gen_if #(
  parameter int unsigned DATAWIDTH_BUS   = 8,
  parameter int unsigned DATAWIDTH_NIVEL = 2
);
  logic [DATAWIDTH_NIVEL-1:0] REGDI_LANE_NVL_IN;
  logic                       REGDI_LANE_CN_IN;
  logic                       REGDI_LANE_DIR_IN;
  logic                       REGDI_LANE_PAUSE_IN;
  logic [DATAWIDTH_BUS-1:0]   REGDI_LANE_DATAPARALLEL_OUT;
  logic                       REGDI_LANE_STEP_OUT;
  logic [DATAWIDTH_NIVEL-1:0] REGDI_LANE_NVL_OUT;

  modport master (
    output REGDI_LANE_NVL_IN,
    output REGDI_LANE_CN_IN,
    output REGDI_LANE_DIR_IN,
    output REGDI_LANE_PAUSE_IN,
    input  REGDI_LANE_DATAPARALLEL_OUT,
    input  REGDI_LANE_STEP_OUT,
    input  REGDI_LANE_NVL_OUT
  );

  modport slave (
    input  REGDI_LANE_NVL_IN,
    input  REGDI_LANE_CN_IN,
    input  REGDI_LANE_DIR_IN,
    input  REGDI_LANE_PAUSE_IN,
    output REGDI_LANE_DATAPARALLEL_OUT,
    output REGDI_LANE_STEP_OUT,
    output REGDI_LANE_NVL_OUT
  );
endinterface

// File: rtl/regdi_lane_gen.sv
// Frogger vehicle-lane rotator: loads a per-level pattern on a valid level strobe, then rotates
// it once every P cycles, where P is a per-level period and P = 0 means the lane never moves.
module regdi_lane_gen #(
  parameter int unsigned DATAWIDTH_BUS   = 8,
  parameter int unsigned NUM_LEVELS      = 4,
  parameter int unsigned DATAWIDTH_NIVEL = 2,
  parameter int unsigned DATAWIDTH_DIV   = 5,
  parameter logic [(1 << DATAWIDTH_NIVEL)*DATAWIDTH_BUS-1:0] LEVEL_PATTERNS =
    {8'hC6, 8'h92, 8'h88, 8'h00},
  parameter logic [(1 << DATAWIDTH_NIVEL)*DATAWIDTH_DIV-1:0] LEVEL_PERIODS =
    {5'd8, 5'd16, 5'd24, 5'd0}
) (
  input  logic              REGDI_LANE_CLOCK,
  input  logic              REGDI_LANE_RESET,
  regdi_lane_gen_if.slave   lane
);

  localparam int unsigned NumSlots = 1 << DATAWIDTH_NIVEL;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StHold} state_e;

  state_e                     r_state;
  logic [DATAWIDTH_BUS-1:0]   r_bus;
  logic                       r_step;
  logic [DATAWIDTH_NIVEL-1:0] r_level;
  logic [DATAWIDTH_DIV-1:0]   r_cnt;

  logic [DATAWIDTH_BUS-1:0]   w_pat_tab [NumSlots];
  logic [DATAWIDTH_DIV-1:0]   w_per_tab [NumSlots];
  logic [NumSlots-1:0]        w_lvl_ok;
  logic [DATAWIDTH_BUS-1:0]   w_pattern;
  logic [DATAWIDTH_DIV-1:0]   w_period;
  logic [DATAWIDTH_BUS-1:0]   w_rot;
  logic                       w_cn_valid;
  logic                       w_tick;

  // Unpack the flat parameter tables; slots at or above NUM_LEVELS are never selectable.
  for (genvar g = 0; g < NumSlots; g++) begin : g_tab
    assign w_pat_tab[g] = LEVEL_PATTERNS[g*DATAWIDTH_BUS +: DATAWIDTH_BUS];
    assign w_per_tab[g] = LEVEL_PERIODS[g*DATAWIDTH_DIV +: DATAWIDTH_DIV];
    assign w_lvl_ok[g]  = (g < NUM_LEVELS);
  end

  assign w_cn_valid = lane.REGDI_LANE_CN_IN & w_lvl_ok[lane.REGDI_LANE_NVL_IN];
  assign w_pattern  = w_pat_tab[r_level];
  assign w_period   = w_per_tab[r_level];
  assign w_tick     = (w_period != '0) && (r_cnt == w_period - 1'b1);
  assign w_rot      = lane.REGDI_LANE_DIR_IN ? {r_bus[0], r_bus[DATAWIDTH_BUS-1:1]}
                                             : {r_bus[DATAWIDTH_BUS-2:0], r_bus[DATAWIDTH_BUS-1]};

  always_ff @(posedge REGDI_LANE_CLOCK or posedge REGDI_LANE_RESET) begin
    if (REGDI_LANE_RESET) begin
      r_state <= StIdle;
      r_bus   <= '0;
      r_step  <= 1'b0;
      r_level <= '0;
      r_cnt   <= '0;
    end else begin
      r_step <= 1'b0;
      // A valid load wins over pause and over a tick landing on the same edge.
      if (w_cn_valid) begin
        r_level <= lane.REGDI_LANE_NVL_IN;
        r_cnt   <= '0;
        r_state <= StLoad;
      end else begin
        unique case (r_state)
          StIdle: begin
            r_bus <= '0;
          end
          StLoad: begin
            r_bus   <= w_pattern;
            r_cnt   <= '0;
            r_state <= lane.REGDI_LANE_PAUSE_IN ? StHold : StRun;
          end
          StRun: begin
            if (lane.REGDI_LANE_PAUSE_IN) begin
              r_state <= StHold;
            end else if (w_period == '0) begin
              r_cnt <= '0;
            end else if (w_tick) begin
              r_cnt  <= '0;
              r_bus  <= w_rot;
              r_step <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          StHold: begin
            if (!lane.REGDI_LANE_PAUSE_IN) begin
              r_state <= StRun;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign lane.REGDI_LANE_DATAPARALLEL_OUT = r_bus;
  assign lane.REGDI_LANE_STEP_OUT         = r_step;
  assign lane.REGDI_LANE_NVL_OUT          = r_level;

endmodule

// File: tb/tb_regdi_lane_gen.sv
// Bench for regdi_lane_gen: directed vector table, hand-written corner sequences, and a random
// phase checked against a cycle model built from the lane rules (pattern, period, rotate).
module tb_regdi_lane_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regdi_lane_gen_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_NIVEL(2)) lif ();
  regdi_lane_gen_if #(.DATAWIDTH_BUS(8), .DATAWIDTH_NIVEL(2)) lif3 ();

  regdi_lane_gen #(.NUM_LEVELS(4)) dut (
    .REGDI_LANE_CLOCK (clk),
    .REGDI_LANE_RESET (rst),
    .lane             (lif)
  );

  regdi_lane_gen #(.NUM_LEVELS(3)) dut3 (
    .REGDI_LANE_CLOCK (clk),
    .REGDI_LANE_RESET (rst),
    .lane             (lif3)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic edge_go();
    @(posedge clk);
    #1;
  endtask

  // Reference model: mode 0 idle, 1 load pending, 2 running, 3 paused.
  typedef struct packed {
    logic [1:0] mode;
    logic [1:0] lvl;
    logic [7:0] bus;
    logic       step;
    logic [7:0] prog;
  } mdl_t;

  logic [7:0] pats [4] = '{8'h00, 8'h88, 8'h92, 8'hC6};
  int         pers [4] = '{0, 24, 16, 8};

  function automatic mdl_t mdl_next(input mdl_t m, input int nlev, input logic cn,
                                    input int nvl, input logic dir, input logic pause);
    mdl_t n;
    logic [7:0] b;
    n = m;
    n.step = 1'b0;
    b = m.bus;
    if (cn && nvl < nlev) begin
      n.lvl  = 2'(nvl);
      n.mode = 2'd1;
      n.prog = '0;
    end else begin
      case (m.mode)
        2'd0: n.bus = 8'h00;
        2'd1: begin
          n.bus  = pats[m.lvl];
          n.prog = '0;
          n.mode = pause ? 2'd3 : 2'd2;
        end
        2'd2: begin
          if (pause) n.mode = 2'd3;
          else if (pers[m.lvl] > 0) begin
            n.prog = m.prog + 8'd1;
            if (int'(n.prog) == pers[m.lvl]) begin
              n.prog = '0;
              n.bus  = dir ? ((b >> 1) | (b << 7)) : ((b << 1) | (b >> 7));
              n.step = 1'b1;
            end
          end
        end
        default: if (!pause) n.mode = 2'd2;
      endcase
    end
    return n;
  endfunction

  typedef struct packed {
    logic       cn;
    logic [1:0] nvl;
    logic       dir;
    logic       pause;
    logic [7:0] reps;
    logic [7:0] exp_bus;
    logic       exp_step;
    logic [1:0] exp_nvl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t vec(input logic cn, input logic [1:0] nvl, input logic dir,
                               input logic pause, input int reps, input logic [7:0] eb,
                               input logic es, input logic [1:0] en);
    vec_t v;
    v = '{cn: cn, nvl: nvl, dir: dir, pause: pause, reps: 8'(reps),
          exp_bus: eb, exp_step: es, exp_nvl: en};
    return v;
  endfunction

  task automatic drive(input logic cn, input logic [1:0] nvl, input logic dir, input logic pause);
    lif.REGDI_LANE_CN_IN    = cn;
    lif.REGDI_LANE_NVL_IN   = nvl;
    lif.REGDI_LANE_DIR_IN   = dir;
    lif.REGDI_LANE_PAUSE_IN = pause;
  endtask

  task automatic drive3(input logic cn, input logic [1:0] nvl, input logic dir,
                        input logic pause);
    lif3.REGDI_LANE_CN_IN    = cn;
    lif3.REGDI_LANE_NVL_IN   = nvl;
    lif3.REGDI_LANE_DIR_IN   = dir;
    lif3.REGDI_LANE_PAUSE_IN = pause;
  endtask

  task automatic step3(input logic cn, input logic [1:0] nvl, input logic [7:0] eb,
                       input logic es, input logic [1:0] en, input string nm);
    drive3(cn, nvl, 1'b0, 1'b0);
    edge_go();
    chk({nm, " bus"},  lif3.REGDI_LANE_DATAPARALLEL_OUT, eb);
    chk({nm, " step"}, lif3.REGDI_LANE_STEP_OUT, es);
    chk({nm, " nvl"},  lif3.REGDI_LANE_NVL_OUT, en);
  endtask

  mdl_t m4, m3;

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    drive3(1'b0, 2'd0, 1'b0, 1'b0);
    #12;
    chk("reset bus",  lif.REGDI_LANE_DATAPARALLEL_OUT, 8'h00);
    chk("reset step", lif.REGDI_LANE_STEP_OUT, 1'b0);
    chk("reset nvl",  lif.REGDI_LANE_NVL_OUT, 2'd0);
    rst = 1'b0;

    // Level 3 (C6, P=8) right, dir flip, pause at count 5, then P=0 level and load under pause.
    tbl.push_back(vec(1, 3, 1, 0, 1,  8'h00, 0, 3));
    tbl.push_back(vec(0, 0, 1, 0, 1,  8'hC6, 0, 3));
    tbl.push_back(vec(0, 0, 1, 0, 7,  8'hC6, 0, 3));
    tbl.push_back(vec(0, 0, 1, 0, 1,  8'h63, 1, 3));
    tbl.push_back(vec(0, 0, 1, 0, 7,  8'h63, 0, 3));
    tbl.push_back(vec(0, 0, 1, 0, 1,  8'hB1, 1, 3));
    tbl.push_back(vec(0, 0, 0, 0, 7,  8'hB1, 0, 3));
    tbl.push_back(vec(0, 0, 0, 0, 1,  8'h63, 1, 3));
    tbl.push_back(vec(0, 0, 0, 0, 5,  8'h63, 0, 3));
    tbl.push_back(vec(0, 0, 0, 1, 20, 8'h63, 0, 3));
    tbl.push_back(vec(0, 0, 0, 0, 1,  8'h63, 0, 3));
    tbl.push_back(vec(0, 0, 0, 0, 2,  8'h63, 0, 3));
    tbl.push_back(vec(0, 0, 0, 0, 1,  8'hC6, 1, 3));
    tbl.push_back(vec(1, 0, 0, 0, 1,  8'hC6, 0, 0));
    tbl.push_back(vec(0, 0, 0, 0, 1,  8'h00, 0, 0));
    tbl.push_back(vec(0, 0, 0, 0, 30, 8'h00, 0, 0));
    tbl.push_back(vec(1, 2, 0, 1, 1,  8'h00, 0, 2));
    tbl.push_back(vec(0, 0, 0, 1, 1,  8'h92, 0, 2));
    tbl.push_back(vec(0, 0, 0, 1, 10, 8'h92, 0, 2));
    tbl.push_back(vec(0, 0, 0, 0, 1,  8'h92, 0, 2));
    tbl.push_back(vec(0, 0, 0, 0, 15, 8'h92, 0, 2));
    tbl.push_back(vec(0, 0, 0, 0, 1,  8'h25, 1, 2));
    tbl.push_back(vec(0, 0, 0, 0, 3,  8'h25, 0, 2));

    foreach (tbl[i]) begin
      for (int r = 0; r < int'(tbl[i].reps); r++) begin
        drive(tbl[i].cn, tbl[i].nvl, tbl[i].dir, tbl[i].pause);
        edge_go();
        chk($sformatf("tbl%0d.%0d bus", i, r),  lif.REGDI_LANE_DATAPARALLEL_OUT, tbl[i].exp_bus);
        chk($sformatf("tbl%0d.%0d step", i, r), lif.REGDI_LANE_STEP_OUT, tbl[i].exp_step);
        chk($sformatf("tbl%0d.%0d nvl", i, r),  lif.REGDI_LANE_NVL_OUT, tbl[i].exp_nvl);
      end
    end

    // Asynchronous reset while running, asserted and checked between clock edges.
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async rst bus",  lif.REGDI_LANE_DATAPARALLEL_OUT, 8'h00);
    chk("async rst step", lif.REGDI_LANE_STEP_OUT, 1'b0);
    chk("async rst nvl",  lif.REGDI_LANE_NVL_OUT, 2'd0);
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      edge_go();
      chk($sformatf("post rst idle bus %0d", i), lif.REGDI_LANE_DATAPARALLEL_OUT, 8'h00);
      chk($sformatf("post rst idle nvl %0d", i), lif.REGDI_LANE_NVL_OUT, 2'd0);
    end

    // Three-level build: a load request for level 3 is out of range and must be ignored.
    step3(1'b1, 2'd3, 8'h00, 1'b0, 2'd0, "l3 idle ignore");
    step3(1'b1, 2'd1, 8'h00, 1'b0, 2'd1, "l3 cn1");
    step3(1'b0, 2'd0, 8'h88, 1'b0, 2'd1, "l3 load");
    for (int i = 0; i < 10; i++) step3(1'b0, 2'd0, 8'h88, 1'b0, 2'd1, $sformatf("l3 run%0d", i));
    step3(1'b1, 2'd3, 8'h88, 1'b0, 2'd1, "l3 bad cn");
    for (int i = 0; i < 12; i++) step3(1'b0, 2'd0, 8'h88, 1'b0, 2'd1, $sformatf("l3 wait%0d", i));
    step3(1'b0, 2'd0, 8'h11, 1'b1, 2'd1, "l3 tick");
    step3(1'b0, 2'd0, 8'h11, 1'b0, 2'd1, "l3 after");

    // Random phase against the model for both builds.
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 1'b0);
    drive3(1'b0, 2'd0, 1'b0, 1'b0);
    m4 = '0;
    m3 = '0;
    #3 rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      logic cn, cn3;
      logic [1:0] nv, nv3;
      cn  = ($urandom_range(0, 29) == 0);
      cn3 = ($urandom_range(0, 29) == 0);
      nv  = 2'($urandom_range(0, 3));
      nv3 = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) lif.REGDI_LANE_DIR_IN = ~lif.REGDI_LANE_DIR_IN;
      if ($urandom_range(0, 11) == 0) lif.REGDI_LANE_PAUSE_IN = ~lif.REGDI_LANE_PAUSE_IN;
      if ($urandom_range(0, 7) == 0) lif3.REGDI_LANE_DIR_IN = ~lif3.REGDI_LANE_DIR_IN;
      if ($urandom_range(0, 11) == 0) lif3.REGDI_LANE_PAUSE_IN = ~lif3.REGDI_LANE_PAUSE_IN;
      lif.REGDI_LANE_CN_IN   = cn;
      lif.REGDI_LANE_NVL_IN  = nv;
      lif3.REGDI_LANE_CN_IN  = cn3;
      lif3.REGDI_LANE_NVL_IN = nv3;
      edge_go();
      m4 = mdl_next(m4, 4, cn, int'(nv), lif.REGDI_LANE_DIR_IN, lif.REGDI_LANE_PAUSE_IN);
      m3 = mdl_next(m3, 3, cn3, int'(nv3), lif3.REGDI_LANE_DIR_IN, lif3.REGDI_LANE_PAUSE_IN);
      chk($sformatf("rnd%0d bus", c),   lif.REGDI_LANE_DATAPARALLEL_OUT, m4.bus);
      chk($sformatf("rnd%0d step", c),  lif.REGDI_LANE_STEP_OUT, m4.step);
      chk($sformatf("rnd%0d nvl", c),   lif.REGDI_LANE_NVL_OUT, m4.lvl);
      chk($sformatf("rnd3_%0d bus", c), lif3.REGDI_LANE_DATAPARALLEL_OUT, m3.bus);
      chk($sformatf("rnd3_%0d step", c), lif3.REGDI_LANE_STEP_OUT, m3.step);
      chk($sformatf("rnd3_%0d nvl", c), lif3.REGDI_LANE_NVL_OUT, m3.lvl);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
